// File: rtl/dm_store_pkg.sv
// Shared constants and state type for the MEM-stage store path (dm_store_unit).
package dm_store_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   localparam int BASE_MASK_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } store_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane math for stores: byte mask and data shifted across two
// adjacent words, plus a legality flag for funct3.
module store_lane_align
   import dm_store_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rs2,
   output logic [7:0]  mask8,
   output logic [63:0] data64,
   output logic        legal
);

   logic [BASE_MASK_W-1:0] base;

   always_comb begin
      base  = '0;
      legal = 1'b0;
      case (funct3)
         F3_SB: begin
            base  = 4'b0001;
            legal = 1'b1;
         end
         F3_SH: begin
            base  = 4'b0011;
            legal = 1'b1;
         end
         F3_SW: begin
            base  = 4'b1111;
            legal = 1'b1;
         end
         default: begin
            base  = '0;
            legal = 1'b0;
         end
      endcase
   end

   assign mask8  = {4'b0000, base} << off;
   assign data64 = {32'h0000_0000, rs2} << {off, 3'b000};

endmodule

// File: rtl/dm_store_unit.sv
// MEM-stage store path: byte-lane enables, lane-aligned data and DM handshake.
// Define MISALIGN_SPLIT_EN to split word-crossing stores into LO/HI beats.
module dm_store_unit
   import dm_store_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_store,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rs2_data,
   input  logic [2:0]        mem_funct3,
   output logic              dm_req,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_web,
   output logic [31:0]       dm_din,
   input  logic              dm_ready,
   output logic              store_stall,
   output logic              store_err
);

   localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

   store_state_t state, state_nxt;

   logic [7:0]  mask8;
   logic [63:0] data64;
   logic        legal;
   logic        allowed;
   logic        need_hi;
   logic        beat_timeout;
   logic [7:0]  wait_cnt;
   logic [3:0]  hi_web_p1;
   logic [31:0] hi_din_p1;

   store_lane_align u_align (
      .funct3 (mem_funct3),
      .off    (mem_addr[1:0]),
      .rs2    (mem_rs2_data),
      .mask8  (mask8),
      .data64 (data64),
      .legal  (legal)
   );

`ifdef MISALIGN_SPLIT_EN
   assign allowed = legal;

   // high-beat lanes held from IDLE until the LO beat is accepted
   always_ff @(posedge clk) begin
      if (state == IDLE && mem_store && allowed) begin
         hi_web_p1 <= mask8[7:4];
         hi_din_p1 <= data64[63:32];
      end
   end
`else
   logic unused_hi;

   assign allowed   = legal && (mask8[7:4] == 4'b0000);
   assign hi_web_p1 = 4'b0000;
   assign hi_din_p1 = 32'h0000_0000;
   assign unused_hi = ^data64[63:32];
`endif

   assign need_hi      = |hi_web_p1;
   assign beat_timeout = !dm_ready && (wait_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_store) begin
               state_nxt = allowed ? LO : DONE;
            end
         end
         LO: begin
            if (dm_ready) begin
               state_nxt = need_hi ? HI : DONE;
            end else if (beat_timeout) begin
               state_nxt = DONE;
            end
         end
         HI: begin
            if (dm_ready || beat_timeout) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      store_stall = 1'b0;
      case (state)
         IDLE:    store_stall = mem_store;
         LO, HI:  store_stall = 1'b1;
         default: store_stall = 1'b0;
      endcase
   end

   // DM beat registers, error pulse and per-beat wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         dm_req    <= 1'b0;
         dm_addr   <= '0;
         dm_web    <= 4'b0000;
         dm_din    <= 32'h0000_0000;
         store_err <= 1'b0;
         wait_cnt  <= 8'd0;
      end else begin
         store_err <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_store) begin
                  wait_cnt <= 8'd0;
                  if (allowed) begin
                     dm_req  <= 1'b1;
                     dm_addr <= {mem_addr[ADDR_W-1:2], 2'b00};
                     dm_web  <= mask8[3:0];
                     dm_din  <= data64[31:0];
                  end else begin
                     store_err <= 1'b1;
                  end
               end
            end
            LO, HI: begin
               if (dm_ready) begin
                  wait_cnt <= 8'd0;
                  if (state == LO && need_hi) begin
                     dm_addr <= dm_addr + WORD_STEP;
                     dm_web  <= hi_web_p1;
                     dm_din  <= hi_din_p1;
                  end else begin
                     dm_req <= 1'b0;
                     dm_web <= 4'b0000;
                     dm_din <= 32'h0000_0000;
                  end
               end else if (beat_timeout) begin
                  wait_cnt  <= 8'd0;
                  dm_req    <= 1'b0;
                  dm_web    <= 4'b0000;
                  dm_din    <= 32'h0000_0000;
                  store_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               dm_req <= 1'b0;
               dm_web <= 4'b0000;
               dm_din <= 32'h0000_0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_store_unit.sv
// Scoreboard bench for dm_store_unit: expected DM beats are queued by the
// stimulus and popped by a monitor whenever a beat is accepted.
module tb_dm_store_unit;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  web;
      logic [31:0] din;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        mem_store;
   logic [31:0] mem_addr;
   logic [31:0] mem_rs2_data;
   logic [2:0]  mem_funct3;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic [3:0]  dm_web;
   logic [31:0] dm_din;
   logic        dm_ready;
   logic        store_stall;
   logic        store_err;

   int    n_cmp = 0;
   int    n_bad = 0;
   beat_t exp_q[$];
   beat_t mon_e;

   dm_store_unit #(
      .ADDR_W      (32),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_store    (mem_store),
      .mem_addr     (mem_addr),
      .mem_rs2_data (mem_rs2_data),
      .mem_funct3   (mem_funct3),
      .dm_req       (dm_req),
      .dm_addr      (dm_addr),
      .dm_web       (dm_web),
      .dm_din       (dm_din),
      .dm_ready     (dm_ready),
      .store_stall  (store_stall),
      .store_err    (store_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      beat_t b;
      b.addr = a;
      b.web  = w;
      b.din  = d;
      exp_q.push_back(b);
   endtask

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && dm_req && dm_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_unexpected: got addr=0x%0h web=%b din=0x%0h, expected no beat",
                     dm_addr, dm_web, dm_din);
         end else begin
            mon_e = exp_q.pop_front();
            check("beat", {dm_addr, dm_web, dm_din}, {mon_e.addr, mon_e.web, mon_e.din});
         end
      end
   end

   // ready_lat: 0 = ready from the start, N>0 = ready raised after N stall
   // cycles have been seen, negative = never ready.
   task automatic run_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input int ready_lat,
                            input int exp_stall, input int exp_req, input int exp_err);
      int n_stall = 0;
      int n_req   = 0;
      int n_err   = 0;
      int cyc     = 0;
      bit done    = 1'b0;
      @(posedge clk); #1;
      mem_store    = 1'b1;
      mem_addr     = addr;
      mem_rs2_data = data;
      mem_funct3   = f3;
      dm_ready     = (ready_lat == 0);
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (store_stall) n_stall++;
         if (dm_req) n_req++;
         if (store_err) n_err++;
         if (!store_stall) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            if (cyc == 0) begin
               mem_store    = 1'b0;
               mem_addr     = ~addr;
               mem_rs2_data = ~data;
               mem_funct3   = 3'b011;
            end
            if (ready_lat > 0 && n_stall == ready_lat) dm_ready = 1'b1;
         end
         cyc++;
      end
      check({name, "_completes"}, done, 1'b1);
      @(posedge clk);
      @(negedge clk);
      if (store_err) n_err++;
      check({name, "_idle_after"}, {store_stall, dm_req}, 2'b00);
      check({name, "_stall_cycles"}, n_stall, exp_stall);
      check({name, "_req_cycles"}, n_req, exp_req);
      check({name, "_err_cycles"}, n_err, exp_err);
      dm_ready = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      mem_store    = 1'b0;
      mem_addr     = 32'h0;
      mem_rs2_data = 32'h0;
      mem_funct3   = 3'b000;
      dm_ready     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {dm_req, dm_addr, dm_web, dm_din, store_err, store_stall}, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      push_beat(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
      run_store("sw_aligned", 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 0, 2, 1, 0);

      push_beat(32'h0000_0100, 4'b1000, 32'hA500_0000);
      run_store("sb_off3", 32'h0000_0103, 32'h0000_00A5, 3'b000, 0, 2, 1, 0);

      push_beat(32'h0000_0100, 4'b1100, 32'h1234_0000);
      run_store("sh_off2", 32'h0000_0102, 32'h0000_1234, 3'b001, 0, 2, 1, 0);

      push_beat(32'h0000_0100, 4'b0110, 32'h00BE_EF00);
      run_store("sh_off1", 32'h0000_0101, 32'h0000_BEEF, 3'b001, 0, 2, 1, 0);

      push_beat(32'h0000_0000, 4'b0001, 32'h1234_5678);
      run_store("sb_off0", 32'h0000_0000, 32'h1234_5678, 3'b000, 0, 2, 1, 0);

`ifdef MISALIGN_SPLIT_EN
      push_beat(32'h0000_00FC, 4'b1100, 32'h3344_0000);
      push_beat(32'h0000_0100, 4'b0011, 32'h0000_1122);
      run_store("sw_split", 32'h0000_00FE, 32'h1122_3344, 3'b010, 0, 3, 2, 0);

      push_beat(32'h0000_0200, 4'b1000, 32'hCD00_0000);
      push_beat(32'h0000_0204, 4'b0001, 32'h0000_00AB);
      run_store("sh_split", 32'h0000_0203, 32'h0000_ABCD, 3'b001, 0, 3, 2, 0);

      push_beat(32'hFFFF_FFFC, 4'b1110, 32'hBBCC_DD00);
      push_beat(32'h0000_0000, 4'b0001, 32'h0000_00AA);
      run_store("sw_wrap", 32'hFFFF_FFFD, 32'hAABB_CCDD, 3'b010, 0, 3, 2, 0);
`else
      run_store("sw_misalign", 32'h0000_00FE, 32'h1122_3344, 3'b010, 0, 1, 0, 1);
      run_store("sh_misalign", 32'h0000_0203, 32'h0000_ABCD, 3'b001, 0, 1, 0, 1);
      run_store("sw_wrap_misalign", 32'hFFFF_FFFD, 32'hAABB_CCDD, 3'b010, 0, 1, 0, 1);
`endif

      run_store("f3_011", 32'h0000_0100, 32'h5555_5555, 3'b011, 0, 1, 0, 1);
      run_store("f3_111", 32'h0000_0104, 32'h6666_6666, 3'b111, 0, 1, 0, 1);

      push_beat(32'h0000_0500, 4'b1111, 32'h0BAD_F00D);
      run_store("sw_wait2", 32'h0000_0500, 32'h0BAD_F00D, 3'b010, 3, 4, 3, 0);

      run_store("sw_timeout", 32'h0000_0300, 32'h7777_7777, 3'b010, -1, 5, 4, 1);

      push_beat(32'h0000_0304, 4'b1111, 32'hCAFE_F00D);
      run_store("sw_after_to", 32'h0000_0304, 32'hCAFE_F00D, 3'b010, 0, 2, 1, 0);

      // reset while the LO beat is outstanding; ready in the same cycle is discarded
      @(posedge clk); #1;
      mem_store    = 1'b1;
      mem_addr     = 32'h0000_0400;
      mem_rs2_data = 32'h8888_8888;
      mem_funct3   = 3'b010;
      dm_ready     = 1'b0;
      @(posedge clk); #1;
      mem_store = 1'b0;
      @(negedge clk);
      check("rst_lo_req_before", {dm_req, store_stall}, 2'b11);
      #1;
      rst      = 1'b1;
      dm_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_lo_outputs", {dm_req, dm_addr, dm_web, dm_din, store_err, store_stall}, '0);
      @(negedge clk);
      check("rst_lo_no_req", {dm_req, store_err}, 2'b00);
      dm_ready = 1'b0;

      push_beat(32'h0000_0404, 4'b0001, 32'h0000_0042);
      run_store("sb_after_rst", 32'h0000_0404, 32'h0000_0042, 3'b000, 0, 2, 1, 0);

      repeat (2) @(negedge clk);
      check("beats_outstanding", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
